// File: rtl/mux_pkg.sv
// Shared definitions for the channel mux/demux library: FSM state encoding
// and the index-width helper.
package mux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Width of an index that can address n items; never narrower than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdm_chan_counter.sv
// Modulo-N channel index counter with clear, load-to-one and increment
// controls (priority in that order); flags the last channel of a frame.
module tdm_chan_counter
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [CW-1:0] idx,
  output logic          last
);

  logic [CW-1:0] idx_q, idx_d;

  // NOTE: idx_d is given a default before any branch so no latch is inferred.
  always_comb begin
    idx_d = idx_q;
    if (clr)        idx_d = '0;
    else if (load1) idx_d = CW'(1);
    else if (inc)   idx_d = (idx_q == CW'(N - 1)) ? '0 : idx_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx  = idx_q;
  assign last = (idx_q == CW'(N - 1));

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: realigns a round-robin serial word stream on
// its frame marker and presents each completed frame on a valid/ready output.
module tdm_demux
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        din,
  input  logic                din_valid,
  input  logic                din_sync,
  output logic [N*W-1:0]      frame_data,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                locked,
  output logic [clog2(N)-1:0] cur_chan,
  output logic                sync_err,
  output logic                overflow,
  input  logic                err_clr
);

  localparam int CW = clog2(N);

  state_e              state_q, state_d;
  logic [(N-1)*W-1:0]  shadow_q;       // channels 0..N-2, channel 0 in the low bits
  logic [N*W-1:0]      frame_data_q;
  logic                frame_valid_q;
  logic                sync_err_q;
  logic                overflow_q;

  logic [CW-1:0]       idx;
  logic                last;
  logic                cnt_clr, cnt_load1, cnt_inc;
  logic                wr_shadow;
  logic [CW-1:0]       wr_idx;
  logic                serr_ev;
  logic                complete;
  logic                commit;

  tdm_chan_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .idx   (idx),
    .last  (last)
  );

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    wr_shadow = 1'b0;
    wr_idx    = din_sync ? '0 : idx;
    serr_ev   = 1'b0;
    complete  = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (din_sync) begin
          wr_shadow = 1'b1;
          cnt_load1 = 1'b1;
          state_d   = LOCKED;
        end
      end else if (din_sync) begin
        // A marker anywhere but channel 0 restarts the frame on this word.
        wr_shadow = 1'b1;
        cnt_load1 = 1'b1;
        serr_ev   = (idx != '0);
      end else if (idx == '0) begin
        serr_ev   = 1'b1;
        cnt_clr   = 1'b1;
        state_d   = HUNT;
      end else if (last) begin
        complete  = 1'b1;
        cnt_inc   = 1'b1;
      end else begin
        wr_shadow = 1'b1;
        cnt_inc   = 1'b1;
      end
    end
  end

  assign commit = complete && (!frame_valid_q || frame_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      // NOTE: the shadow buffer is reset so a frame after reset never carries stale words.
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < N - 1; k++) begin
        if (wr_shadow && wr_idx == CW'(k)) shadow_q[k*W +: W] <= din;
      end

      if (commit) begin
        frame_data_q  <= {din, shadow_q};
        frame_valid_q <= 1'b1;
      end else if (frame_valid_q && frame_ready) begin
        frame_valid_q <= 1'b0;
      end

      if (serr_ev)      sync_err_q <= 1'b1;
      else if (err_clr) sync_err_q <= 1'b0;

      if (complete && !commit) overflow_q <= 1'b1;
      else if (err_clr)        overflow_q <= 1'b0;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign locked      = (state_q == LOCKED);
  assign cur_chan    = idx;
  assign sync_err    = sync_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed framing scenarios followed by
// randomized traffic, all compared against a queue-based frame model.
module tb_tdm_demux;
  import mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    din = '0;
  logic            din_valid = 1'b0;
  logic            din_sync = 1'b0;
  logic            frame_ready = 1'b0;
  logic            err_clr = 1'b0;
  logic [N*W-1:0]  frame_data;
  logic            frame_valid;
  logic            locked;
  logic [CW-1:0]   cur_chan;
  logic            sync_err;
  logic            overflow;

  tdm_demux #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_sync    (din_sync),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .locked      (locked),
    .cur_chan    (cur_chan),
    .sync_err    (sync_err),
    .overflow    (overflow),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: the partial frame is simply the list of words collected so far.
  bit              m_locked;
  logic [W-1:0]    m_words[$];
  logic            m_fv, m_serr, m_ovf;
  logic [N*W-1:0]  m_fd;
  logic            tb_rdy;

  task automatic model_reset();
    m_locked = 0;
    m_words.delete();
    m_fv   = 1'b0;
    m_serr = 1'b0;
    m_ovf  = 1'b0;
    m_fd   = '0;
  endtask

  task automatic model_step(input logic dv, input logic ds, input logic [W-1:0] d,
                            input logic rdy, input logic clr);
    logic           serr_ev = 1'b0;
    logic           ovf_ev  = 1'b0;
    logic           done    = 1'b0;
    logic [N*W-1:0] nf      = '0;
    if (dv) begin
      if (!m_locked) begin
        if (ds) begin
          m_words  = {d};
          m_locked = 1;
        end
      end else if (ds) begin
        if (m_words.size() != 0) serr_ev = 1'b1;
        m_words = {d};
      end else if (m_words.size() == 0) begin
        serr_ev  = 1'b1;
        m_locked = 0;
      end else begin
        m_words.push_back(d);
        if (m_words.size() == N) begin
          for (int k = 0; k < N; k++) nf[k*W +: W] = m_words[k];
          m_words.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      if (!m_fv || rdy) begin
        m_fd = nf;
        m_fv = 1'b1;
      end else begin
        ovf_ev = 1'b1;
      end
    end else if (m_fv && rdy) begin
      m_fv = 1'b0;
    end
    if (serr_ev) m_serr = 1'b1;
    else if (clr) m_serr = 1'b0;
    if (ovf_ev) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_all();
    check("frame_valid", frame_valid, m_fv);
    check("frame_data",  frame_data,  m_fd);
    check("locked",      locked,      m_locked);
    check("cur_chan",    cur_chan,    m_locked ? m_words.size() : 0);
    check("sync_err",    sync_err,    m_serr);
    check("overflow",    overflow,    m_ovf);
  endtask

  task automatic cycle(input logic dv, input logic ds, input logic [W-1:0] d,
                       input logic rdy, input logic clr);
    din_valid   = dv;
    din_sync    = ds;
    din         = d;
    frame_ready = rdy;
    err_clr     = clr;
    @(posedge clk);
    model_step(dv, ds, d, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic feed(input logic [W-1:0] d, input logic ds);
    cycle(1'b1, ds, d, tb_rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy, input logic clr);
    cycle(1'b0, 1'b0, '0, rdy, clr);
  endtask

  // Reset is raised between clock edges to exercise its asynchronous path.
  task automatic do_reset();
    din_valid = 1'b0;
    din_sync  = 1'b0;
    err_clr   = 1'b0;
    rst       = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tb_rdy = 1'b1;
    model_reset();
    #3;

    // 1: basic frame capture with one-cycle latency
    do_reset();
    feed(8'h10, 1); feed(8'h11, 0); feed(8'h12, 0);
    check("t1_not_yet_valid", frame_valid, 1'b0);
    feed(8'h13, 0);
    check("t1_data",   frame_data,  32'h13121110);
    check("t1_valid",  frame_valid, 1'b1);
    check("t1_locked", locked,      1'b1);
    idle(1'b1, 1'b0);

    // 2: unsynchronised words in HUNT are discarded
    do_reset();
    feed(8'hAA, 0); feed(8'hBB, 0);
    check("t2_hunt",  locked,      1'b0);
    check("t2_noval", frame_valid, 1'b0);
    feed(8'h40, 1); feed(8'h41, 0); feed(8'h42, 0); feed(8'h43, 0);
    check("t2_data", frame_data, 32'h43424140);
    idle(1'b1, 1'b0);

    // 3: early marker restarts the frame and stays locked
    feed(8'h20, 1); feed(8'h21, 0);
    feed(8'h30, 1); feed(8'h31, 0); feed(8'h32, 0); feed(8'h33, 0);
    check("t3_serr",   sync_err,   1'b1);
    check("t3_data",   frame_data, 32'h33323130);
    check("t3_locked", locked,     1'b1);
    idle(1'b1, 1'b1);

    // 4: overflow keeps the pending frame; a ready on completion swaps in the new one
    tb_rdy = 1'b0;
    feed(8'h50, 1); feed(8'h51, 0); feed(8'h52, 0); feed(8'h53, 0);
    feed(8'h60, 1); feed(8'h61, 0); feed(8'h62, 0); feed(8'h63, 0);
    check("t4_ovf",  overflow,   1'b1);
    check("t4_keep", frame_data, 32'h53525150);
    feed(8'h70, 1); feed(8'h71, 0); feed(8'h72, 0);
    cycle(1'b1, 1'b0, 8'h73, 1'b1, 1'b0);
    check("t4_swap",  frame_data,  32'h73727170);
    check("t4_valid", frame_valid, 1'b1);
    tb_rdy = 1'b1;
    idle(1'b1, 1'b1);

    // 5: missing marker drops to HUNT; a set in the same cycle as clear wins
    feed(8'h80, 1); feed(8'h81, 0); feed(8'h82, 0); feed(8'h83, 0);
    feed(8'h90, 0);
    check("t5_serr", sync_err, 1'b1);
    check("t5_hunt", locked,   1'b0);
    idle(1'b1, 1'b1);
    check("t5_clr", sync_err, 1'b0);
    feed(8'hA0, 1);
    cycle(1'b1, 1'b1, 8'hA1, 1'b1, 1'b1);
    check("t5_set_wins", sync_err, 1'b1);

    // 6: reset mid-frame, then a clean frame with no stale words
    feed(8'hB1, 0); feed(8'hB2, 0);
    do_reset();
    check("t6_data0", frame_data, 32'h0);
    feed(8'hC0, 1); feed(8'hC1, 0); feed(8'hC2, 0); feed(8'hC3, 0);
    check("t6_data", frame_data, 32'hC3C2C1C0);

    // Random traffic, biased toward well-formed frames with occasional faults
    for (int i = 0; i < 3000; i++) begin
      logic dv, ds, rdy, clr;
      dv  = ($urandom % 5) != 0;
      ds  = (m_words.size() == 0) ? (($urandom % 8) != 0) : (($urandom % 12) == 0);
      rdy = ($urandom % 2) != 0;
      clr = ($urandom % 16) == 0;
      if (($urandom % 500) == 0) do_reset();
      cycle(dv, ds, W'($urandom), rdy, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
